gpio_pin_ctrl: RTL

- Per-pin GPIO datapath directly downstream of the per-pin direction RS flops.
- Takes each pin's direction bit and the output-data writes.
- Drives pad output and output-enable.
- Synchronizes pad inputs into the clock domain, detects edges and latches sticky interrupt status toward the APB slave.

---
 rtl/gpio_pin_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/gpio_pin_ctrl.sv
// Per-pin GPIO datapath: output register and enable, input synchronizer, edge detect, sticky irq.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_pin_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] mode_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
    $error("gpio_pin_ctrl: DEBOUNCE_CYCLES out of range 1..255");
  end

  logic [WIDTH-1:0] out_reg_q;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mode_q;
  logic [WIDTH-1:0] irq_status_q;
  logic [WIDTH-1:0] irq_status_d;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_reg_q    <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      mode_q       <= '0;
      irq_status_q <= '0;
    end else begin
      if (wr_en) begin
        out_reg_q <= wr_data;
      end
      sync1_q      <= pad_in;
      sync2_q      <= sync1_q;
      prev_q       <= filt;
      mode_q       <= mode_in;
      irq_status_q <= irq_status_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // filt only follows sync2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // An edge only counts when the pin was an input on both this and the previous cycle
  assign qual = mode_in & mode_q;
  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;
  assign set  = qual & ((rise & irq_rise_en) | (fall & irq_fall_en));

  assign irq_status_d = (irq_status_q & ~irq_clr) | set;

  assign pad_oe     = ~mode_in;
  assign pad_out    = out_reg_q & ~mode_in;
  assign rd_data    = (mode_in & filt) | (~mode_in & out_reg_q);
  assign irq_status = irq_status_q;
  assign irq        = |irq_status_q;

endmodule
